// File: rtl/lsu_data_memory.sv
// Byte-addressed RV32I data memory with sized loads/stores, fixed-latency pipelined response.
// Optional macro DMEM_INIT_CLEAR_EN: zero the whole array after reset before accepting requests.
module lsu_data_memory #(
  parameter int DEPTH        = 4096,
  parameter int ADDR_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err
);

  localparam int IDX_W = $clog2(DEPTH);

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("lsu_data_memory: READ_LATENCY must be in 1..4");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("lsu_data_memory: DEPTH must be a power of 2 and >= 2");
  end

  // Upper address bits are intentionally dropped so the array wraps.
  if (ADDR_WIDTH > IDX_W + 2) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[ADDR_WIDTH-1:IDX_W+2];
  end

  logic [31:0]      mem [DEPTH];

  logic [IDX_W-1:0] idx;
  logic [1:0]       off;
  logic [1:0]       size;
  logic             zext;
  logic             illegal;
  logic             misaligned;
  logic             err;
  logic             accept;
  logic             do_write;
  logic [3:0]       lane_en;
  logic [31:0]      lane_data;
  logic [31:0]      raw_word;
  logic [31:0]      shifted;
  logic [31:0]      load_data;

  assign accept   = req_valid && req_ready;
  assign do_write = accept && req_we && !err;

  // Decode the request: legality, alignment, store lanes and extended load value.
  always_comb begin
    idx        = req_addr[IDX_W+1:2];
    off        = req_addr[1:0];
    size       = req_funct3[1:0];
    zext       = req_funct3[2];
    illegal    = req_we ? (req_funct3 > 3'b010)
                        : !(req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misaligned = ((size == 2'b01) && off[0]) || ((size == 2'b10) && (off != 2'b00));
    err        = illegal || misaligned;

    lane_en   = 4'b0000;
    lane_data = req_wdata;
    case (size)
      2'b00: begin
        lane_en   = 4'b0001 << off;
        lane_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        lane_en   = off[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{req_wdata[15:0]}};
      end
      2'b10: lane_en = 4'b1111;
      default: lane_en = 4'b0000;
    endcase

    raw_word = mem[idx];
    shifted  = raw_word >> {off, 3'b000};
    case (size)
      2'b00:   load_data = zext ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = zext ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = raw_word;
    endcase
  end

`ifdef DMEM_INIT_CLEAR_EN
  typedef enum logic {INIT, RUN} state_t;

  state_t           state;
  logic [IDX_W-1:0] clr_cnt;
  logic             ready_q;

  // INIT sweeps every word once; ready rises together with the move to RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= INIT;
      clr_cnt <= '0;
      ready_q <= 1'b0;
    end else if (state == INIT) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == IDX_W'(DEPTH - 1)) begin
        state   <= RUN;
        ready_q <= 1'b1;
      end
    end
  end

  assign req_ready = ready_q;
`else
  assign req_ready = 1'b1;
`endif

  // Storage has no reset so that stores survive a reset pulse.
  always_ff @(posedge clk) begin
`ifdef DMEM_INIT_CLEAR_EN
    if (state == INIT) begin
      mem[clr_cnt] <= '0;
    end else
`endif
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[idx][8*i +: 8] <= lane_data[8*i +: 8];
      end
    end
  end

  logic        v_pipe [READ_LATENCY];
  logic [31:0] d_pipe [READ_LATENCY];
  logic        e_pipe [READ_LATENCY];

  // Stage 0 captures the response at the accept edge; later stages only add delay.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        v_pipe[i] <= 1'b0;
        d_pipe[i] <= '0;
        e_pipe[i] <= 1'b0;
      end
    end else begin
      v_pipe[0] <= accept;
      d_pipe[0] <= (accept && !req_we && !err) ? load_data : 32'b0;
      e_pipe[0] <= accept && err;
      for (int i = 1; i < READ_LATENCY; i++) begin
        v_pipe[i] <= v_pipe[i-1];
        d_pipe[i] <= d_pipe[i-1];
        e_pipe[i] <= e_pipe[i-1];
      end
    end
  end

  assign rsp_valid = v_pipe[READ_LATENCY-1];
  assign rsp_rdata = d_pipe[READ_LATENCY-1];
  assign rsp_err   = e_pipe[READ_LATENCY-1];

endmodule
